// File: rtl/debug_step_ctrl.sv
// Run/halt/single-step controller for firmware under debug, with a masked breakpoint and a trace word.
// step_en, bp_hit, steps_left and debug_wireout are registered; cmd_ready and halted are decoded from state.
// cmd_ready drops while STEPPING; halt_req and breakpoints win over any command taken in the same cycle.
module debug_step_ctrl #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_op,
    input  logic [COUNT_W-1:0] cmd_count,
    output logic               cmd_ready,
    input  logic               halt_req,
    input  logic               bp_enable,
    input  logic [23:0]        bp_value,
    input  logic [23:0]        bp_mask,
    input  logic [23:0]        probe,
    output logic               step_en,
    output logic [31:0]        debug_wireout,
    output logic               halted,
    output logic               bp_hit,
    output logic [COUNT_W-1:0] steps_left
);

    typedef enum logic [1:0] {
        HALTED   = 2'b00,
        RUNNING  = 2'b01,
        STEPPING = 2'b10
    } state_t;

    localparam logic [1:0] OP_HALT = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;

    state_t             state;
    state_t             state_nxt;
    logic [COUNT_W-1:0] left_nxt;
    logic [5:0]         tag;
    logic               active;
    logic               bp_match;
    logic               cmd_accept;

    assign cmd_ready = (state != STEPPING);
    assign halted    = (state == HALTED);

    always_comb begin
        state_nxt  = state;
        left_nxt   = steps_left;
        active     = (state != HALTED);
        bp_match   = active && bp_enable && (((probe ^ bp_value) & bp_mask) == 24'd0);
        cmd_accept = cmd_valid && cmd_ready;

        if (halt_req || bp_match) begin
            state_nxt = HALTED;
            left_nxt  = '0;
        end else if (state == STEPPING) begin
            // The cycle showing steps_left=1 is the last enabled one.
            if (steps_left <= COUNT_W'(1)) begin
                state_nxt = HALTED;
                left_nxt  = '0;
            end else begin
                left_nxt = steps_left - COUNT_W'(1);
            end
        end else if (cmd_accept) begin
            case (cmd_op)
                OP_HALT: begin
                    state_nxt = HALTED;
                    left_nxt  = '0;
                end
                OP_RUN: state_nxt = RUNNING;
                OP_STEP: begin
                    if (cmd_count != '0) begin
                        state_nxt = STEPPING;
                        left_nxt  = cmd_count;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= HALTED;
            steps_left    <= '0;
            step_en       <= 1'b0;
            bp_hit        <= 1'b0;
            tag           <= 6'd0;
            debug_wireout <= 32'd0;
        end else begin
            state         <= state_nxt;
            steps_left    <= left_nxt;
            // Registered from the next state so it tracks the state it reports.
            step_en       <= (state_nxt != HALTED);
            bp_hit        <= bp_match;
            tag           <= tag + {5'd0, step_en};
            debug_wireout <= {state, tag, probe};
        end
    end

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Bench for debug_step_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_debug_step_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_count;
    logic        cmd_ready;
    logic        halt_req;
    logic        bp_enable;
    logic [23:0] bp_value;
    logic [23:0] bp_mask;
    logic [23:0] probe;
    logic        step_en;
    logic [31:0] debug_wireout;
    logic        halted;
    logic        bp_hit;
    logic [15:0] steps_left;

    int checks   = 0;
    int failures = 0;

    // Model: mode 0=halted 1=running 2=stepping
    int          m_mode;
    int unsigned m_left;
    int          m_tag;
    logic        m_bp_hit;
    logic [31:0] m_wire;

    always #5 clk = ~clk;

    debug_step_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_op        (cmd_op),
        .cmd_count     (cmd_count),
        .cmd_ready     (cmd_ready),
        .halt_req      (halt_req),
        .bp_enable     (bp_enable),
        .bp_value      (bp_value),
        .bp_mask       (bp_mask),
        .probe         (probe),
        .step_en       (step_en),
        .debug_wireout (debug_wireout),
        .halted        (halted),
        .bp_hit        (bp_hit),
        .steps_left    (steps_left)
    );

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic clk_edge;
        bit match;
        @(posedge clk);
        if (reset) begin
            m_mode = 0; m_left = 0; m_tag = 0; m_bp_hit = 1'b0; m_wire = 32'd0;
        end else begin
            m_wire = {m_mode[1:0], m_tag[5:0], probe};
            if (m_mode != 0) m_tag = (m_tag + 1) % 64;
            match = (m_mode != 0) && bp_enable && ((probe & bp_mask) == (bp_value & bp_mask));
            m_bp_hit = match;
            if (halt_req || match) begin
                m_mode = 0; m_left = 0;
            end else if (m_mode == 2) begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = 0;
            end else if (cmd_valid) begin
                case (cmd_op)
                    2'd0: m_mode = 0;
                    2'd1: m_mode = 1;
                    2'd2: if (cmd_count != 0) begin m_mode = 2; m_left = cmd_count; end
                    default: ;
                endcase
            end
        end
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] cnt);
        cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt;
        clk_edge();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_count = 16'd3; halt_req = 1'b1;
        bp_enable = 1'b0; bp_value = 24'd0; bp_mask = 24'd0; probe = 24'h123456;
        clk_edge();
        clk_edge();
        checks++; if (step_en !== 1'b0) begin failures++; $display("FAIL reset_step_en got=%b exp=0", step_en); end
        checks++; if (debug_wireout !== 32'd0) begin failures++; $display("FAIL reset_wireout got=%h exp=0", debug_wireout); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL reset_halted got=%b exp=1", halted); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (steps_left !== 16'd0) begin failures++; $display("FAIL reset_steps_left got=%0d exp=0", steps_left); end
        checks++; if (bp_hit !== 1'b0) begin failures++; $display("FAIL reset_bp_hit got=%b exp=0", bp_hit); end
        reset = 1'b0; cmd_valid = 1'b0; halt_req = 1'b0;
        clk_edge();
        checks++; if (halted !== 1'b1 || step_en !== 1'b0) begin failures++; $display("FAIL reset_cmd_ignored halted=%b step_en=%b exp halted=1 step_en=0", halted, step_en); end
    endtask

    task automatic test_step5;
        send(2'd2, 16'd5);
        for (int i = 0; i < 5; i++) begin
            checks++; if (step_en !== 1'b1) begin failures++; $display("FAIL step5_en[%0d] got=%b exp=1", i, step_en); end
            checks++; if (steps_left !== 16'(5 - i)) begin failures++; $display("FAIL step5_left[%0d] got=%0d exp=%0d", i, steps_left, 5 - i); end
            checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL step5_ready[%0d] got=%b exp=0", i, cmd_ready); end
            clk_edge();
        end
        checks++; if (halted !== 1'b1 || step_en !== 1'b0 || steps_left !== 16'd0) begin
            failures++; $display("FAIL step5_done halted=%b step_en=%b left=%0d exp 1/0/0", halted, step_en, steps_left); end
        clk_edge();
        checks++; if (debug_wireout[31:24] !== {2'b00, 6'd5}) begin failures++; $display("FAIL step5_tag got=%h exp=05", debug_wireout[31:24]); end
    endtask

    task automatic test_breakpoint;
        int k;
        bp_enable = 1'b1; bp_value = 24'h00ABCD; bp_mask = 24'h00FFFF;
        probe = 24'h000001;
        send(2'd1, 16'd0);
        k = $urandom_range(3, 8);
        for (int i = 0; i < k; i++) begin
            checks++; if (step_en !== 1'b1 || bp_hit !== 1'b0) begin failures++; $display("FAIL bp_running[%0d] step_en=%b bp_hit=%b exp 1/0", i, step_en, bp_hit); end
            probe = 24'($urandom);
            if (probe[15:0] == 16'hABCD) probe[0] = ~probe[0];
            clk_edge();
        end
        probe = 24'h12ABCD;
        clk_edge();
        checks++; if (step_en !== 1'b0) begin failures++; $display("FAIL bp_stop_step_en got=%b exp=0", step_en); end
        checks++; if (bp_hit !== 1'b1) begin failures++; $display("FAIL bp_hit_pulse got=%b exp=1", bp_hit); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL bp_halted got=%b exp=1", halted); end
        clk_edge();
        checks++; if (bp_hit !== 1'b0) begin failures++; $display("FAIL bp_hit_one_cycle got=%b exp=0", bp_hit); end
        bp_enable = 1'b0;
    endtask

    task automatic test_halt_priority;
        send(2'd2, 16'd10);
        for (int i = 0; i < 2; i++) begin
            checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL hp_ready[%0d] got=%b exp=0", i, cmd_ready); end
            clk_edge();
        end
        checks++; if (cmd_ready !== 1'b0 || steps_left !== 16'd8) begin failures++; $display("FAIL hp_step3 ready=%b left=%0d exp 0/8", cmd_ready, steps_left); end
        halt_req = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1;
        clk_edge();
        halt_req = 1'b0; cmd_valid = 1'b0;
        checks++; if (halted !== 1'b1 || steps_left !== 16'd0 || step_en !== 1'b0) begin
            failures++; $display("FAIL hp_stepping halted=%b left=%0d step_en=%b exp 1/0/0", halted, steps_left, step_en); end
        clk_edge();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL hp_run_dropped got=%b exp=1", halted); end
        send(2'd1, 16'd0);
        halt_req = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd2; cmd_count = 16'd7;
        clk_edge();
        halt_req = 1'b0; cmd_valid = 1'b0;
        checks++; if (halted !== 1'b1 || steps_left !== 16'd0) begin failures++; $display("FAIL hp_running halted=%b left=%0d exp 1/0", halted, steps_left); end
    endtask

    task automatic test_zero_mask;
        int cnt;
        bp_enable = 1'b1; bp_mask = 24'd0; bp_value = 24'($urandom);
        send(2'd1, 16'd0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (step_en) cnt++;
            clk_edge();
        end
        checks++; if (cnt !== 1) begin failures++; $display("FAIL zero_mask_steps got=%0d exp=1", cnt); end
        bp_enable = 1'b0;
    endtask

    task automatic test_tag_wrap;
        int prev;
        bit wrap_seen;
        send(2'd1, 16'd0);
        prev = -1; wrap_seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            probe = 24'($urandom);
            clk_edge();
            checks++; if (debug_wireout[31:30] !== 2'b01) begin failures++; $display("FAIL wrap_state[%0d] got=%b exp=01", i, debug_wireout[31:30]); end
            if (prev >= 0) begin
                checks++; if (int'(debug_wireout[29:24]) != (prev + 1) % 64) begin
                    failures++; $display("FAIL wrap_tag[%0d] got=%0d exp=%0d", i, debug_wireout[29:24], (prev + 1) % 64); end
                if (prev == 63 && debug_wireout[29:24] == 6'd0) wrap_seen = 1'b1;
            end
            prev = int'(debug_wireout[29:24]);
        end
        checks++; if (wrap_seen !== 1'b1) begin failures++; $display("FAIL wrap_seen got=%b exp=1", wrap_seen); end
        send(2'd0, 16'd0);
    endtask

    task automatic test_noop_cmds;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_count = 16'd0;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL noop_ready got=%b exp=1", cmd_ready); end
        clk_edge();
        checks++; if (halted !== 1'b1 || step_en !== 1'b0) begin failures++; $display("FAIL noop_step0 halted=%b step_en=%b exp 1/0", halted, step_en); end
        cmd_op = 2'd3; cmd_count = 16'($urandom);
        clk_edge();
        cmd_valid = 1'b0;
        checks++; if (halted !== 1'b1 || step_en !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL noop_rsvd halted=%b step_en=%b ready=%b exp 1/0/1", halted, step_en, cmd_ready); end
        send(2'd1, 16'd0);
        send(2'd2, 16'd0);
        send(2'd3, 16'd9);
        checks++; if (halted !== 1'b0 || step_en !== 1'b1 || cmd_ready !== 1'b1 || steps_left !== 16'd0) begin
            failures++; $display("FAIL noop_running halted=%b step_en=%b ready=%b left=%0d exp 0/1/1/0", halted, step_en, cmd_ready, steps_left); end
        send(2'd0, 16'd0);
    endtask

    task automatic test_reset_abort;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) send(2'd2, 16'd20); else send(2'd1, 16'd0);
            for (int i = 0; i < 3; i++) clk_edge();
            reset = 1'b1;
            clk_edge();
            reset = 1'b0;
            checks++; if (step_en !== 1'b0 || halted !== 1'b1 || steps_left !== 16'd0) begin
                failures++; $display("FAIL reset_abort[%0d] step_en=%b halted=%b left=%0d exp 0/1/0", pass, step_en, halted, steps_left); end
            clk_edge();
            checks++; if (step_en !== 1'b0) begin failures++; $display("FAIL reset_abort_after[%0d] got=%b exp=0", pass, step_en); end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom % 200) == 0;
            cmd_valid = ($urandom % 3) == 0;
            cmd_op    = 2'($urandom);
            cmd_count = 16'($urandom % 8);
            halt_req  = ($urandom % 50) == 0;
            bp_enable = ($urandom % 4) == 0;
            bp_value  = 24'($urandom);
            bp_mask   = 24'($urandom & $urandom & $urandom);
            probe     = (($urandom % 5) == 0) ? 24'hFFFFFF : 24'($urandom);
            clk_edge();
            checks++; if (step_en !== (m_mode != 0) || halted !== (m_mode == 0) || cmd_ready !== (m_mode != 2)) begin
                failures++; $display("FAIL rnd_state[%0d] step_en=%b halted=%b ready=%b exp mode=%0d", i, step_en, halted, cmd_ready, m_mode); end
            checks++; if (steps_left !== m_left[15:0] || bp_hit !== m_bp_hit) begin
                failures++; $display("FAIL rnd_count[%0d] left=%0d bp_hit=%b exp %0d/%b", i, steps_left, bp_hit, m_left, m_bp_hit); end
            checks++; if (debug_wireout !== m_wire) begin failures++; $display("FAIL rnd_wire[%0d] got=%h exp=%h", i, debug_wireout, m_wire); end
            checks++; if (debug_wireout === 32'hFFFF_FFFF) begin failures++; $display("FAIL rnd_marker[%0d] got=%h exp!=ffffffff", i, debug_wireout); end
        end
        reset = 1'b0; cmd_valid = 1'b0; halt_req = 1'b0; bp_enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_step5();
        test_breakpoint();
        test_halt_priority();
        test_zero_mask();
        test_tag_wrap();
        test_noop_cmds();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
